// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end:
//   - fetch_state_t    : fetch FSM state encoding (WAIT / HOLD / DROP)
//   - NOP_INSTR        : canonical RV32I NOP (addi x0, x0, 0)
//   - DEFAULT_RESET_PC : default fetch PC loaded on reset
//   - pc_next_seq()    : sequential next-PC helper (wraps modulo 2^32)
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,   // request outstanding for PCF
        ST_HOLD = 2'd1,   // response captured while fetch stage stalled
        ST_DROP = 2'd2    // request outstanding whose response is stale
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential successor of a PC; 32-bit add, wraps naturally.
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with stall and flush.
// Priority: reset > flush > stall > load > bubble.
//   i_clk     : clock (rising edge)
//   i_rst     : synchronous active-high reset
//   i_load    : fetch stage presents a valid instruction this cycle
//   i_stall   : hold current contents (StallD)
//   i_flush   : insert a bubble, overrides stall and load (FlushD)
//   i_pc      : PC of the instruction being loaded
//   i_instr   : instruction word being loaded
//   o_pc      : PCD
//   o_instr   : InstrD
//   o_valid   : ValidD
// ----------------------------------------------------------------------------
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;

    // IF/ID register update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_pc    <= r_pc;
            r_instr <= r_instr;
            r_valid <= r_valid;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end else begin
            // Decode consumed its instruction and fetch has nothing new:
            // present a bubble, keep PCD for visibility.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch PC register, instruction-memory request FSM and IF/ID register.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds FetchCnt (valid IF/ID loads) and DropCnt (discarded
//   memory responses), both 32-bit, reset to 0, wrapping.
//
// Ports:
//   CPU_CLK   in   clock, rising edge
//   CPU_RST   in   synchronous active-high reset
//   PC_In     in   next PC from the next-PC generator
//   Redirect  in   PC_In is a jump/branch target
//   StallF    in   hold the fetch stage
//   StallD    in   hold the IF/ID register
//   FlushD    in   clear the IF/ID register
//   IReq      out  instruction-memory request
//   IAddr     out  request address (always PCF)
//   IAck      in   response valid this cycle
//   IData     in   response instruction word
//   PCF       out  current fetch PC
//   PCD       out  IF/ID PC
//   InstrD    out  IF/ID instruction
//   ValidD    out  IF/ID valid
//   FetchCnt  out  (FETCH_PERF_CNT_EN only) valid IF/ID loads
//   DropCnt   out  (FETCH_PERF_CNT_EN only) discarded responses
//   FetchBusy out  IReq & ~IAck, for the hazard unit
// ----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PC_In,
    input  logic        Redirect,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IAck,
    input  logic [31:0] IData,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic [31:0] InstrD,
    output logic        ValidD,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FetchCnt,
    output logic [31:0] DropCnt,
`endif
    output logic        FetchBusy
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pcf;
    logic [31:0]  w_pcf_nxt;
    logic [31:0]  r_pend_pc;
    logic [31:0]  w_pend_pc_nxt;
    logic [31:0]  r_hold_instr;
    logic [31:0]  w_hold_instr_nxt;
    logic         w_load;
    logic [31:0]  w_load_instr;
    logic         w_drop;
    logic         w_ireq;

    // Fetch FSM and PC/PendPC/hold-buffer state registers
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_state      <= ST_WAIT;
            r_pcf        <= RESET_PC;
            r_pend_pc    <= 32'h0000_0000;
            r_hold_instr <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pcf        <= w_pcf_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
        end
    end

    // Next-state, next-PC and IF/ID load decisions
    always_comb begin
        w_state_nxt      = r_state;
        w_pcf_nxt        = r_pcf;
        w_pend_pc_nxt    = r_pend_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_load           = 1'b0;
        w_load_instr     = r_hold_instr;
        w_drop           = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (Redirect) begin
                    if (IAck) begin
                        // Response belongs to the wrong path; go straight
                        // to the target.
                        w_drop    = 1'b1;
                        w_pcf_nxt = PC_In;
                    end else begin
                        // Bus still owes us the old response: remember the
                        // target and keep IAddr stable until it arrives.
                        w_pend_pc_nxt = PC_In;
                        w_state_nxt   = ST_DROP;
                    end
                end else if (IAck) begin
                    if (StallF) begin
                        w_hold_instr_nxt = IData;
                        w_state_nxt      = ST_HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_load_instr = IData;
                        w_pcf_nxt    = PC_In;
                    end
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    w_drop           = 1'b1;
                    w_hold_instr_nxt = 32'h0000_0000;
                    w_pcf_nxt        = PC_In;
                    w_state_nxt      = ST_WAIT;
                end else if (!StallF) begin
                    w_load           = 1'b1;
                    w_load_instr     = r_hold_instr;
                    w_hold_instr_nxt = 32'h0000_0000;
                    w_pcf_nxt        = PC_In;
                    w_state_nxt      = ST_WAIT;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (IAck) begin
                    // A redirect arriving with the stale ack is newer than
                    // PendPC, so it wins.
                    w_drop      = 1'b1;
                    w_pcf_nxt   = Redirect ? PC_In : r_pend_pc;
                    w_state_nxt = ST_WAIT;
                end else if (Redirect) begin
                    w_pend_pc_nxt = PC_In;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
            end
        endcase
    end

    // Request is suppressed in any reset cycle; memory abandons it too.
    assign w_ireq    = ~CPU_RST & ((r_state == ST_WAIT) | (r_state == ST_DROP));
    assign IReq      = w_ireq;
    assign IAddr     = r_pcf;
    assign PCF       = r_pcf;
    assign FetchBusy = w_ireq & ~IAck;

    if_id_reg u_if_id_reg (
        .i_clk   (CPU_CLK),
        .i_rst   (CPU_RST),
        .i_load  (w_load),
        .i_stall (StallD),
        .i_flush (FlushD),
        .i_pc    (r_pcf),
        .i_instr (w_load_instr),
        .o_pc    (PCD),
        .o_instr (InstrD),
        .o_valid (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_drop_cnt;
    logic        w_fetch_inc;

    // A load only counts if it actually lands in IF/ID.
    assign w_fetch_inc = w_load & ~StallD & ~FlushD;

    // Performance counters
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_fetch_cnt <= 32'h0000_0000;
            r_drop_cnt  <= 32'h0000_0000;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + {31'd0, w_fetch_inc};
            r_drop_cnt  <= r_drop_cnt + {31'd0, w_drop};
        end
    end

    assign FetchCnt = r_fetch_cnt;
    assign DropCnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Scenario tasks drive the fetch unit; every expected IF/ID load is pushed to
// a queue and a monitor pops it when ValidD shows a fresh load.
// ----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic        redirect = 1'b0;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        iack = 1'b0;
    logic [31:0] idata = 32'h0;
    logic        ireq;
    logic [31:0] iaddr;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] instrd;
    logic        validd;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_fetch = 0;
    int   exp_drop = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CPU_CLK  (clk),
        .CPU_RST  (rst),
        .PC_In    (pc_in),
        .Redirect (redirect),
        .StallF   (stall_f),
        .StallD   (stall_d),
        .FlushD   (flush_d),
        .IReq     (ireq),
        .IAddr    (iaddr),
        .IAck     (iack),
        .IData    (idata),
        .PCF      (pcf),
        .PCD      (pcd),
        .InstrD   (instrd),
        .ValidD   (validd),
`ifdef FETCH_PERF_CNT_EN
        .FetchCnt (fetch_cnt),
        .DropCnt  (drop_cnt),
`endif
        .FetchBusy(busy)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0033;
    endfunction

    // Scoreboard: every unstalled, unflushed edge that leaves ValidD=1 is a load.
    always @(posedge clk) begin : mon
        logic m_rst;
        logic m_sd;
        logic m_fl;
        exp_t e;
        m_rst = rst;
        m_sd  = stall_d;
        m_fl  = flush_d;
        #1;
        if (!m_rst && !m_sd && !m_fl && validd === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: load PCD=%h InstrD=%h, none expected", pcd, instrd);
            end else begin
                e = sb_q.pop_front();
                if (pcd !== e.pc || instrd !== e.instr) begin
                    n_err++;
                    $display("FAIL sb_load: PCD=%h InstrD=%h, expected PCD=%h InstrD=%h",
                             pcd, instrd, e.pc, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait fetch of pc, successor pc+4.
    task automatic fetch_one(input logic [31:0] pc);
        redirect = 1'b0; stall_f = 1'b0; iack = 1'b1;
        idata = instr_of(pc); pc_in = pc + 32'd4;
        #1;
        n_vec++;
        if (iaddr !== pc || ireq !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_req: IAddr=%h IReq=%b Busy=%b, expected IAddr=%h 1 0", iaddr, ireq, busy, pc);
        end
        sb_q.push_back({pc, instr_of(pc)});
        exp_fetch++;
        tick();
        iack = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_vec++;
        if (pcf !== 32'h0 || pcd !== 32'h0 || instrd !== NOP || validd !== 1'b0 || ireq !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: PCF=%h PCD=%h InstrD=%h ValidD=%b IReq=%b Busy=%b, expected 0 0 %h 0 0 0",
                     pcf, pcd, instrd, validd, ireq, busy, NOP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (fetch_cnt !== 32'h0 || drop_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cnt: FetchCnt=%0d DropCnt=%0d, expected 0 0", fetch_cnt, drop_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        n_vec++;
        if (ireq !== 1'b1 || iaddr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: IReq=%b IAddr=%h, expected 1 00000000", ireq, iaddr);
        end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'(i * 4));
        end
        n_vec++;
        if (pcf !== 32'h10) begin
            n_err++;
            $display("FAIL zero_wait_pcf: PCF=%h, expected 00000010", pcf);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            iack = 1'b0; pc_in = 32'h14;
            #1;
            n_vec++;
            if (iaddr !== 32'h10 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL wait_busy[%0d]: IAddr=%h Busy=%b, expected 00000010 1", i, iaddr, busy);
            end
            tick();
        end
        fetch_one(32'h10);
        n_vec++;
        if (pcf !== 32'h14) begin
            n_err++;
            $display("FAIL wait_pcf: PCF=%h, expected 00000014", pcf);
        end
        fetch_one(32'h14); fetch_one(32'h18); fetch_one(32'h1C);
    endtask

    task automatic test_redirect_drop();
        redirect = 1'b1; pc_in = 32'h80; iack = 1'b0;
        tick();
        redirect = 1'b0; pc_in = 32'h24;
        #1;
        n_vec++;
        if (pcf !== 32'h20 || iaddr !== 32'h20 || ireq !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL drop_wait: PCF=%h IAddr=%h IReq=%b Busy=%b, expected 20 20 1 1", pcf, iaddr, ireq, busy);
        end
        tick();
        iack = 1'b1; idata = 32'hBAD0_0001;
        tick();
        iack = 1'b0; exp_drop++;
        n_vec++;
        if (pcf !== 32'h80 || iaddr !== 32'h80) begin
            n_err++;
            $display("FAIL drop_target: PCF=%h IAddr=%h, expected 00000080", pcf, iaddr);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (drop_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL drop_cnt: DropCnt=%0d, expected 1", drop_cnt);
        end
`endif
    endtask

    task automatic test_drop_rewrite();
        redirect = 1'b1; pc_in = 32'h100; iack = 1'b0; tick();
        redirect = 1'b1; pc_in = 32'h200; tick();
        redirect = 1'b0; pc_in = 32'h84; iack = 1'b1; idata = 32'hBAD0_0002; tick();
        iack = 1'b0; exp_drop++;
        n_vec++;
        if (pcf !== 32'h200) begin
            n_err++;
            $display("FAIL drop_latest: PCF=%h, expected 00000200", pcf);
        end
        redirect = 1'b1; pc_in = 32'h300; tick();
        redirect = 1'b1; pc_in = 32'h400; iack = 1'b1; tick();
        redirect = 1'b0; iack = 1'b0; exp_drop++;
        n_vec++;
        if (pcf !== 32'h400) begin
            n_err++;
            $display("FAIL drop_direct: PCF=%h, expected 00000400", pcf);
        end
        fetch_one(32'h400);
    endtask

    task automatic test_stall_hold();
        redirect = 1'b1; iack = 1'b1; pc_in = 32'h30; idata = 32'hBAD0_0003; tick();
        redirect = 1'b0; iack = 1'b0; exp_drop++;
        iack = 1'b1; stall_f = 1'b1; idata = instr_of(32'h30); pc_in = 32'h34;
        tick();
        iack = 1'b0; idata = 32'hBAD0_0004;
        #1;
        n_vec++;
        if (pcf !== 32'h30 || ireq !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_1: PCF=%h IReq=%b Busy=%b, expected 00000030 0 0", pcf, ireq, busy);
        end
        tick();
        n_vec++;
        if (pcf !== 32'h30 || ireq !== 1'b0) begin
            n_err++;
            $display("FAIL hold_2: PCF=%h IReq=%b, expected 00000030 0", pcf, ireq);
        end
        stall_f = 1'b0; pc_in = 32'h34;
        sb_q.push_back({32'h30, instr_of(32'h30)});
        exp_fetch++;
        tick();
        n_vec++;
        if (pcf !== 32'h34 || ireq !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: PCF=%h IReq=%b, expected 00000034 1", pcf, ireq);
        end
    endtask

    task automatic test_hold_redirect();
        iack = 1'b1; stall_f = 1'b1; idata = instr_of(32'h34); pc_in = 32'h38; tick();
        iack = 1'b0; redirect = 1'b1; pc_in = 32'h50; tick();
        redirect = 1'b0; stall_f = 1'b0; exp_drop++;
        n_vec++;
        if (pcf !== 32'h50 || ireq !== 1'b1 || iaddr !== 32'h50) begin
            n_err++;
            $display("FAIL hold_redirect: PCF=%h IReq=%b IAddr=%h, expected 50 1 50", pcf, ireq, iaddr);
        end
    endtask

    task automatic test_stall_flush();
        fetch_one(32'h50); fetch_one(32'h54);
        stall_d = 1'b1; iack = 1'b0; pc_in = 32'h5C; tick();
        n_vec++;
        if (pcd !== 32'h54 || instrd !== instr_of(32'h54) || validd !== 1'b1) begin
            n_err++;
            $display("FAIL stall_d_hold: PCD=%h InstrD=%h ValidD=%b, expected 54 %h 1", pcd, instrd, validd, instr_of(32'h54));
        end
        flush_d = 1'b1; iack = 1'b1; idata = instr_of(32'h58); pc_in = 32'h5C; tick();
        flush_d = 1'b0; stall_d = 1'b0; iack = 1'b0;
        n_vec++;
        if (validd !== 1'b0 || instrd !== NOP || pcf !== 32'h5C) begin
            n_err++;
            $display("FAIL flush_stall: ValidD=%b InstrD=%h PCF=%h, expected 0 %h 0000005c", validd, instrd, pcf, NOP);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; iack = 1'b1; pc_in = 32'hFFFF_FFFC; tick();
        redirect = 1'b0; iack = 1'b0; exp_drop++;
        fetch_one(32'hFFFF_FFFC);
        n_vec++;
        if (pcf !== 32'h0) begin
            n_err++;
            $display("FAIL pc_wrap: PCF=%h, expected 00000000", pcf);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (fetch_cnt !== 32'(exp_fetch) || drop_cnt !== 32'(exp_drop)) begin
            n_err++;
            $display("FAIL perf_cnt: FetchCnt=%0d DropCnt=%0d, expected %0d %0d", fetch_cnt, drop_cnt, exp_fetch, exp_drop);
        end
`endif
    endtask

    task automatic test_reset_in_drop();
        fetch_one(32'h0);
        redirect = 1'b1; pc_in = 32'h700; iack = 1'b0; tick();
        redirect = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (ireq !== 1'b0 || pcf !== 32'h4) begin
            n_err++;
            $display("FAIL rst_drop_req: IReq=%b PCF=%h, expected 0 00000004", ireq, pcf);
        end
        tick();
        n_vec++;
        if (pcf !== 32'h0 || validd !== 1'b0 || instrd !== NOP || pcd !== 32'h0) begin
            n_err++;
            $display("FAIL rst_drop_state: PCF=%h ValidD=%b InstrD=%h PCD=%h, expected 0 0 %h 0", pcf, validd, instrd, pcd, NOP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (fetch_cnt !== 32'h0 || drop_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL rst_drop_cnt: FetchCnt=%0d DropCnt=%0d, expected 0 0", fetch_cnt, drop_cnt);
        end
`endif
        rst = 1'b0;
        fetch_one(32'h0);
        n_vec++;
        if (pcf !== 32'h4) begin
            n_err++;
            $display("FAIL rst_drop_pend: PCF=%h, expected 00000004", pcf);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_redirect_drop();
        test_drop_rewrite();
        test_stall_hold();
        test_hold_redirect();
        test_stall_flush();
        test_wrap();
        test_reset_in_drop();
        tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected loads never seen, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
